// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU data-memory path: size defaults, responder
// FSM state encoding and the load/store funct encoding used on the CPU side.
package cpu_pkg;

  localparam int DMEM_WIDTH = 32;
  localparam int DMEM_SIZE  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    FUNCT_NONE  = 2'd0,
    FUNCT_LOAD  = 2'd1,
    FUNCT_STORE = 2'd2
  } mem_funct_e;

  function automatic logic funct_is_store(input mem_funct_e f);
    return f == FUNCT_STORE;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the CPU MEMORY stage (master) and the data
// memory responder (slave).
interface data_memory_responder_if
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DMEM_WIDTH,
  parameter int ADDR_W = 32
);

  // Both channels are valid/ready: a beat transfers on a rising edge where
  // valid & ready are both 1; the sender holds valid and payload stable until then.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WIDTH-1:0]  resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/sp_word_ram.sv
// Single-port synchronous word RAM; read data registers on every enabled edge
// (read-first), write commits when we is also set. Contents are never reset.
module sp_word_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data memory responder: accepts one load/store at a time, performs it after
// LATENCY cycles (legal 1..15) and holds the response until the CPU takes it.
module data_memory_responder
  import cpu_pkg::*;
#(
  parameter int WIDTH    = DMEM_WIDTH,
  parameter int MEM_SIZE = DMEM_SIZE,
  parameter int ADDR_W   = 32,
  parameter int LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  data_memory_responder_if.slave  bus,
  output dmem_state_e             state_dbg
);

  localparam int AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

  dmem_state_e       state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata;
  logic              accept, enter_resp, resp_in_range;
  logic              sel_write, sel_in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_wdata, ram_rdata;

  assign accept = bus.req_valid && (state == ST_IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: if (accept) begin
        cnt_nx   = 4'd1;
        state_nx = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_nx = cnt + 4'd1;
        if (cnt == 4'(LATENCY - 1)) state_nx = ST_RESP;
      end
      ST_RESP: if (bus.resp_ready) begin
        state_nx = ST_IDLE;
        cnt_nx   = 4'd0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_addr;
        lat_wdata <= bus.req_wdata;
      end
    end
  end

  // With LATENCY=1 the access happens on the accepting edge itself, so the
  // RAM must see the live request rather than the not-yet-latched copy.
  assign sel_write    = (state == ST_IDLE) ? bus.req_write : lat_write;
  assign sel_addr     = (state == ST_IDLE) ? bus.req_addr  : lat_addr;
  assign sel_wdata    = (state == ST_IDLE) ? bus.req_wdata : lat_wdata;
  assign sel_in_range = sel_addr < ADDR_W'(MEM_SIZE);
  assign enter_resp   = (state_nx == ST_RESP) && (state != ST_RESP);

  sp_word_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MEM_SIZE),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .en    (enter_resp && sel_in_range && rst),
    .we    (sel_write),
    .addr  (sel_addr[AW-1:0]),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  assign resp_in_range  = lat_addr < ADDR_W'(MEM_SIZE);
  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.resp_err   = (state == ST_RESP) && !resp_in_range;
  assign bus.resp_rdata = ((state == ST_RESP) && !lat_write && resp_in_range) ? ram_rdata : '0;
  assign state_dbg      = state;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (LATENCY 2, 1, 4) share the
// request wires; sel routes valid/ready to one of them. Expected responses go via exp_q.
module tb_data_memory_responder;
  import cpu_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared drive signals
  int          sel = 0;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;

  data_memory_responder_if #(.WIDTH(W), .ADDR_W(32)) bus2 ();
  data_memory_responder_if #(.WIDTH(W), .ADDR_W(32)) bus1 ();
  data_memory_responder_if #(.WIDTH(W), .ADDR_W(32)) bus4 ();
  dmem_state_e st2, st1, st4;

  assign bus2.req_valid  = req_valid && (sel == 0);
  assign bus1.req_valid  = req_valid && (sel == 1);
  assign bus4.req_valid  = req_valid && (sel == 2);
  assign bus2.resp_ready = resp_ready && (sel == 0);
  assign bus1.resp_ready = resp_ready && (sel == 1);
  assign bus4.resp_ready = resp_ready && (sel == 2);
  assign bus2.req_write = req_write; assign bus2.req_addr = req_addr; assign bus2.req_wdata = req_wdata;
  assign bus1.req_write = req_write; assign bus1.req_addr = req_addr; assign bus1.req_wdata = req_wdata;
  assign bus4.req_write = req_write; assign bus4.req_addr = req_addr; assign bus4.req_wdata = req_wdata;

  data_memory_responder #(.WIDTH(W), .MEM_SIZE(1024), .ADDR_W(32), .LATENCY(2))
    dut_l2 (.clk(clk), .rst(rst), .bus(bus2), .state_dbg(st2));
  data_memory_responder #(.WIDTH(W), .MEM_SIZE(1024), .ADDR_W(32), .LATENCY(1))
    dut_l1 (.clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));
  data_memory_responder #(.WIDTH(W), .MEM_SIZE(1024), .ADDR_W(32), .LATENCY(4))
    dut_l4 (.clk(clk), .rst(rst), .bus(bus4), .state_dbg(st4));

  // observed outputs of the selected instance
  logic        o_req_ready, o_resp_valid, o_resp_err, o_busy;
  logic [31:0] o_resp_rdata;
  dmem_state_e o_state;
  always_comb begin
    o_req_ready = bus2.req_ready; o_resp_valid = bus2.resp_valid; o_resp_err = bus2.resp_err;
    o_busy = bus2.busy; o_resp_rdata = bus2.resp_rdata; o_state = st2;
    if (sel == 1) begin
      o_req_ready = bus1.req_ready; o_resp_valid = bus1.resp_valid; o_resp_err = bus1.resp_err;
      o_busy = bus1.busy; o_resp_rdata = bus1.resp_rdata; o_state = st1;
    end else if (sel == 2) begin
      o_req_ready = bus4.req_ready; o_resp_valid = bus4.resp_valid; o_resp_err = bus4.resp_err;
      o_busy = bus4.busy; o_resp_rdata = bus4.resp_rdata; o_state = st4;
    end
  end

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // One complete transaction on the selected instance: checks latency, data,
  // hold under back-pressure and the return to IDLE.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int lat, input int bp, input string name);
    int acc;
    bit got;
    logic [EW-1:0] act, exp_v;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; resp_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (o_req_ready) got = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_accept: req_ready never rose, got 0 expected 1", name);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({exp_err, exp_rd});
    acc = cyc + 1;
    @(posedge clk); #1;
    // scramble request wires: responder must use the latched copy
    req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_resp_valid) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_resp: resp_valid never rose, got 0 expected 1", name);
      return;
    end
    vectors++;
    if (cyc != acc + lat - 1) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d expected %0d cycles", name, cyc - acc + 1, lat);
    end
    act   = {o_resp_err, o_resp_rdata};
    exp_v = exp_q.pop_front();
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s_data: got err=%b rdata=%h expected err=%b rdata=%h",
               name, act[W], act[W-1:0], exp_v[W], exp_v[W-1:0]);
    end
    vectors++;
    if (o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy: got busy=%b req_ready=%b expected busy=1 req_ready=0", name, o_busy, o_req_ready);
    end
    for (int b = 0; b < bp; b++) begin
      vectors++;
      if (o_resp_valid !== 1'b1 || {o_resp_err, o_resp_rdata} !== exp_v || o_req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_hold%0d: got valid=%b err=%b rdata=%h req_ready=%b expected valid=1 err=%b rdata=%h req_ready=0",
                 name, b, o_resp_valid, o_resp_err, o_resp_rdata, o_req_ready, exp_v[W], exp_v[W-1:0]);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    vectors++;
    if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0 || o_resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_complete: got valid=%b ready=%b busy=%b err=%b expected valid=0 ready=1 busy=0 err=0",
               name, o_resp_valid, o_req_ready, o_busy, o_resp_err);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_busy: got %b expected 1", o_busy);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_busy !== 1'b0 ||
        o_resp_err !== 1'b0 || o_resp_rdata !== 32'd0 || o_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_async: got ready=%b valid=%b busy=%b err=%b rdata=%h state=%0d expected 1 0 0 0 0 0",
               o_req_ready, o_resp_valid, o_busy, o_resp_err, o_resp_rdata, o_state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_store_load();
    sel = 0;
    do_txn(1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'd0, 2, 0, "l2_store5");
    do_txn(1'b0, 32'd5, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0, "l2_load5");
  endtask

  task automatic test_back_pressure();
    sel = 0;
    do_txn(1'b0, 32'd5, 32'h0, 1'b0, 32'hDEADBEEF, 2, 4, "l2_bp_load5");
  endtask

  task automatic test_out_of_range();
    sel = 0;
    do_txn(1'b1, 32'd0, 32'h55, 1'b0, 32'd0, 2, 0, "oor_init0");
    do_txn(1'b1, 32'd1024, 32'd1, 1'b1, 32'd0, 2, 0, "oor_store1024");
    do_txn(1'b0, 32'd0, 32'h0, 1'b0, 32'h55, 2, 0, "oor_load0");
    do_txn(1'b0, 32'd1024, 32'h0, 1'b1, 32'd0, 2, 1, "oor_load1024");
  endtask

  task automatic test_back_to_back();
    int acc[2];
    int n_acc, n_resp;
    logic [EW-1:0] act, exp_v;
    logic [31:0] d0, d1;
    d0 = $urandom; d1 = $urandom;
    sel = 1; n_acc = 0; n_resp = 0;
    @(negedge clk);
    resp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd3; req_wdata = d0;
    for (int i = 0; i < 16 && n_resp < 2; i++) begin
      if (o_resp_valid) begin
        act = {o_resp_err, o_resp_rdata};
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : {1'b1, 32'hFFFF_FFFF};
        vectors++;
        if (n_resp >= n_acc || cyc != acc[n_resp] || act !== exp_v) begin
          miscompares++;
          $display("FAIL b2b_resp%0d: got err=%b rdata=%h cyc=%0d expected err=%b rdata=%h one cycle after accept",
                   n_resp, act[W], act[W-1:0], cyc, exp_v[W], exp_v[W-1:0]);
        end
        n_resp++;
        @(negedge clk);
      end else if (o_req_ready && req_valid) begin
        exp_q.push_back('0);
        acc[n_acc] = cyc + 1;
        n_acc++;
        @(posedge clk); #1;
        if (n_acc == 1) begin req_addr = 32'd4; req_wdata = d1; end
        else req_valid = 1'b0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0; resp_ready = 1'b0;
    vectors++;
    if (n_resp != 2 || n_acc != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d accepts %0d responses expected 2 and 2", n_acc, n_resp);
    end else begin
      vectors++;
      if (acc[1] - acc[0] != 2) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d expected 2 cycles", acc[1] - acc[0]);
      end
    end
    do_txn(1'b0, 32'd3, 32'h0, 1'b0, d0, 1, 0, "l1_load3");
    do_txn(1'b0, 32'd4, 32'h0, 1'b0, d1, 1, 0, "l1_load4");
  endtask

  task automatic test_reset_during_wait();
    bit seen;
    sel = 2;
    do_txn(1'b1, 32'd7, 32'h1234, 1'b0, 32'd0, 4, 0, "l4_store7_prev");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd7; req_wdata = 32'd9; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    vectors++;
    if (o_state !== ST_WAIT) begin
      miscompares++;
      $display("FAIL rstwait_pre_state: got %0d expected %0d", o_state, ST_WAIT);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0 || o_busy !== 1'b0 || o_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL rstwait_async: got ready=%b valid=%b busy=%b state=%0d expected 1 0 0 0",
               o_req_ready, o_resp_valid, o_busy, o_state);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_resp_valid) seen = 1'b1;
    end
    resp_ready = 1'b0;
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL rstwait_no_resp: got resp_valid=1 expected 0");
    end
    do_txn(1'b0, 32'd7, 32'h0, 1'b0, 32'h1234, 4, 0, "l4_load7_after_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_store_load();
    test_back_pressure();
    test_out_of_range();
    test_back_to_back();
    test_reset_during_wait();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
